// File: rtl/cvxif_copro_pkg.sv
// Shared definitions for the CV-X-IF coprocessor pipe: opcode, funct3 encodings
// and the tag that travels alongside each result through the pipeline and FIFO.
package cvxif_copro_pkg;

   localparam logic [6:0]  OPCODE_COPRO = 7'b0001011;
   localparam int unsigned MAX_ID_WIDTH = 8;

   typedef enum logic [2:0] {
      FUNCT3_ADD = 3'd0,
      FUNCT3_XOR = 3'd1,
      FUNCT3_NOP = 3'd2
   } funct3_e;

   // IDs are stored zero-extended to MAX_ID_WIDTH so the tag layout is fixed.
   typedef struct packed {
      logic                    valid;
      logic                    killed;
      logic                    wb;
      logic [MAX_ID_WIDTH-1:0] id;
      logic [4:0]              rd;
   } pipe_tag_t;

   function automatic pipe_tag_t mark_killed(input pipe_tag_t               tag,
                                             input logic                    kill,
                                             input logic [MAX_ID_WIDTH-1:0] kill_id);
      pipe_tag_t res;
      res = tag;
      if (kill && tag.valid && (tag.id == kill_id)) begin
         res.killed = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/cvxif_copro_fifo.sv
// Result FIFO for the coprocessor pipe. Registered output (no fall-through);
// every stored entry whose ID matches an active kill gets its killed flag set.
module cvxif_copro_fifo
   import cvxif_copro_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned Depth = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  pipe_tag_t               push_tag_i,
   input  logic [XLEN-1:0]         push_data_i,
   input  logic                    pop_i,
   input  logic                    kill_i,
   input  logic [MAX_ID_WIDTH-1:0] kill_id_i,
   output logic                    head_valid_o,
   output pipe_tag_t               head_tag_o,
   output logic [XLEN-1:0]         head_data_o,
   output logic                    full_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   pipe_tag_t       mem_tag  [Depth];
   logic [XLEN-1:0] mem_data [Depth];
   logic            do_push;
   logic            do_pop;

   assign head_valid_o = (wr_ptr != rd_ptr);
   assign full_o       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop       = pop_i & head_valid_o;
   assign do_push      = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; occupancy is defined purely by the pointers.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < Depth; i++) begin
         if (do_push && (wr_ptr[AW-1:0] == AW'(i))) begin
            mem_tag[i]  <= push_tag_i;
            mem_data[i] <= push_data_i;
         end else begin
            mem_tag[i]  <= mark_killed(mem_tag[i], kill_i, kill_id_i);
         end
      end
   end

   assign head_tag_o  = mem_tag[rd_ptr[AW-1:0]];
   assign head_data_o = mem_data[rd_ptr[AW-1:0]];

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   push_i |-> (!full_o || do_pop));

endmodule

// File: rtl/cvxif_copro_pipe.sv
// CV-X-IF custom-0 coprocessor: ADD/XOR/NOP, fixed-latency pipeline feeding an
// in-order result FIFO with credit-based flow control and ID-based kills.
module cvxif_copro_pipe
   import cvxif_copro_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned IdWidth = 3,
   parameter int unsigned Latency = 2,
   parameter int unsigned Depth   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               issue_valid_i,
   output logic               issue_ready_o,
   input  logic [31:0]        issue_instr_i,
   input  logic [IdWidth-1:0] issue_id_i,
   input  logic [XLEN-1:0]    issue_rs1_i,
   input  logic [XLEN-1:0]    issue_rs2_i,
   input  logic [1:0]         issue_rs_valid_i,
   output logic               issue_accept_o,
   output logic               issue_writeback_o,
   input  logic               commit_valid_i,
   input  logic [IdWidth-1:0] commit_id_i,
   input  logic               commit_kill_i,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [IdWidth-1:0] result_id_o,
   output logic [4:0]         result_rd_o,
   output logic [XLEN-1:0]    result_data_o,
   output logic               busy_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [CntW-1:0]         count;
   funct3_e                 funct3;
   logic                    dec_accept;
   logic                    dec_wb;
   logic [XLEN-1:0]         dec_result;
   logic                    accepted;
   logic                    kill_en;
   logic [MAX_ID_WIDTH-1:0] kill_id;
   pipe_tag_t               issue_tag;
   pipe_tag_t               exit_tag;
   logic [XLEN-1:0]         exit_data;
   logic                    push;
   logic                    exit_free;
   logic                    head_valid;
   pipe_tag_t               head_tag;
   logic [XLEN-1:0]         head_data;
   logic                    head_free;
   logic                    fifo_full;
   logic                    unused_bits;

   assign funct3 = funct3_e'(issue_instr_i[14:12]);

   always_comb begin
      dec_accept = 1'b0;
      dec_wb     = 1'b0;
      dec_result = '0;
      if (issue_instr_i[6:0] == OPCODE_COPRO) begin
         case (funct3)
            FUNCT3_ADD: begin
               dec_accept = 1'b1;
               dec_wb     = 1'b1;
               dec_result = issue_rs1_i + issue_rs2_i;
            end
            FUNCT3_XOR: begin
               dec_accept = 1'b1;
               dec_wb     = 1'b1;
               dec_result = issue_rs1_i ^ issue_rs2_i;
            end
            FUNCT3_NOP: dec_accept = 1'b1;
            default:    dec_accept = 1'b0;
         endcase
      end
   end

   assign issue_accept_o    = dec_accept;
   assign issue_writeback_o = dec_wb;

   // A credit leaving the FIFO head this cycle can be reused immediately, so a
   // full pipe that is popping still takes a new instruction.
   assign head_free     = head_valid & (head_tag.killed | result_ready_i);
   assign issue_ready_o = ~rst_i & (&issue_rs_valid_i) & ((count < CntW'(Depth)) | head_free);
   assign accepted      = issue_valid_i & issue_ready_o & dec_accept;

   assign kill_en = commit_valid_i & commit_kill_i;
   assign kill_id = MAX_ID_WIDTH'(commit_id_i);

   assign issue_tag = '{valid:  accepted,
                        killed: 1'b0,
                        wb:     dec_wb,
                        id:     MAX_ID_WIDTH'(issue_id_i),
                        rd:     issue_instr_i[11:7]};

   // The FIFO write is the last of the Latency register stages, so only
   // Latency-1 pipeline registers sit between issue and the FIFO.
   generate
      if (Latency == 1) begin : g_direct
         assign exit_tag  = issue_tag;
         assign exit_data = dec_result;
      end else begin : g_stages
         pipe_tag_t       stage_tag  [Latency-1];
         logic [XLEN-1:0] stage_data [Latency-1];

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int i = 0; i < Latency - 1; i++) begin
                  stage_tag[i]  <= '0;
                  stage_data[i] <= '0;
               end
            end else begin
               stage_tag[0]  <= issue_tag;
               stage_data[0] <= dec_result;
               for (int i = 1; i < Latency - 1; i++) begin
                  stage_tag[i]  <= mark_killed(stage_tag[i-1], kill_en, kill_id);
                  stage_data[i] <= stage_data[i-1];
               end
            end
         end

         assign exit_tag  = mark_killed(stage_tag[Latency-2], kill_en, kill_id);
         assign exit_data = stage_data[Latency-2];
      end
   endgenerate

   assign push      = exit_tag.valid & exit_tag.wb & ~exit_tag.killed;
   assign exit_free = exit_tag.valid & ~push;

   cvxif_copro_fifo #(
      .XLEN  (XLEN),
      .Depth (Depth)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push),
      .push_tag_i   (exit_tag),
      .push_data_i  (exit_data),
      .pop_i        (head_free),
      .kill_i       (kill_en),
      .kill_id_i    (kill_id),
      .head_valid_o (head_valid),
      .head_tag_o   (head_tag),
      .head_data_o  (head_data),
      .full_o       (fifo_full)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else begin
         count <= count + CntW'(accepted) - CntW'(exit_free) - CntW'(head_free);
      end
   end

   assign result_valid_o = head_valid & ~head_tag.killed;
   assign result_id_o    = result_valid_o ? head_tag.id[IdWidth-1:0] : '0;
   assign result_rd_o    = result_valid_o ? head_tag.rd : '0;
   assign result_data_o  = result_valid_o ? head_data : '0;
   assign busy_o         = (count != '0);

   assign unused_bits = ^{issue_instr_i[31:15], head_tag.valid, head_tag.wb, head_tag.id, fifo_full};

   a_count_range: assert property (@(posedge clk_i) disable iff (rst_i) count <= CntW'(Depth));

endmodule

// File: tb/tb_cvxif_copro_pipe.sv
// Self-checking bench for cvxif_copro_pipe: directed scenarios plus random
// traffic scored against an in-order result queue with ID-based kills.
module tb_cvxif_copro_pipe;

   localparam int XLEN    = 64;
   localparam int IdWidth = 3;
   localparam int Latency = 2;
   localparam int Depth   = 4;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               issue_valid_i;
   logic               issue_ready_o;
   logic [31:0]        issue_instr_i;
   logic [IdWidth-1:0] issue_id_i;
   logic [XLEN-1:0]    issue_rs1_i;
   logic [XLEN-1:0]    issue_rs2_i;
   logic [1:0]         issue_rs_valid_i;
   logic               issue_accept_o;
   logic               issue_writeback_o;
   logic               commit_valid_i;
   logic [IdWidth-1:0] commit_id_i;
   logic               commit_kill_i;
   logic               result_valid_o;
   logic               result_ready_i;
   logic [IdWidth-1:0] result_id_o;
   logic [4:0]         result_rd_o;
   logic [XLEN-1:0]    result_data_o;
   logic               busy_o;

   always #5 clk_i = ~clk_i;

   cvxif_copro_pipe #(
      .XLEN(XLEN), .IdWidth(IdWidth), .Latency(Latency), .Depth(Depth)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
      .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_rs_valid_i(issue_rs_valid_i),
      .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
      .commit_kill_i(commit_kill_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_rd_o(result_rd_o),
      .result_data_o(result_data_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [IdWidth-1:0] id;
      logic [4:0]         rd;
      logic [XLEN-1:0]    data;
      bit                 killed;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic               obs_ready, obs_acc, obs_wb, obs_rv, obs_busy;
   logic [IdWidth-1:0] obs_id;
   logic [4:0]         obs_rd;
   logic [XLEN-1:0]    obs_data;
   bit                 popped;
   bit                 pop_has_exp;
   exp_t               pop_exp;

   function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                            input logic [6:0] opc);
      return {17'h0, f3, rd, opc};
   endfunction

   function automatic bit mdl_accept(input logic [31:0] ins);
      return (ins[6:0] == 7'h0B) && (ins[14:12] <= 3'd2);
   endfunction

   function automatic bit mdl_wb(input logic [31:0] ins);
      return mdl_accept(ins) && (ins[14:12] != 3'd2);
   endfunction

   function automatic logic [XLEN-1:0] mdl_result(input logic [31:0] ins,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      return (ins[14:12] == 3'd0) ? a + b : a ^ b;
   endfunction

   task automatic drive_idle();
      issue_valid_i  = 1'b0;
      issue_instr_i  = '0;
      issue_id_i     = '0;
      issue_rs1_i    = '0;
      issue_rs2_i    = '0;
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      commit_id_i    = '0;
   endtask

   task automatic set_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [IdWidth-1:0] id,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      issue_valid_i = 1'b1;
      issue_instr_i = mk_instr(f3, rd, 7'h0B);
      issue_id_i    = id;
      issue_rs1_i   = a;
      issue_rs2_i   = b;
   endtask

   // Observes one cycle from the negedge and advances the reference queue:
   // pop first, then this cycle's kill, then this cycle's issue.
   task automatic cycle_step();
      #1;
      obs_ready = issue_ready_o;
      obs_acc   = issue_accept_o;
      obs_wb    = issue_writeback_o;
      obs_rv    = result_valid_o;
      obs_busy  = busy_o;
      obs_id    = result_id_o;
      obs_rd    = result_rd_o;
      obs_data  = result_data_o;
      popped      = obs_rv && result_ready_i;
      pop_has_exp = 0;
      if (popped) begin
         while (exp_q.size() > 0 && exp_q[0].killed) void'(exp_q.pop_front());
         if (exp_q.size() > 0) begin
            pop_exp     = exp_q.pop_front();
            pop_has_exp = 1;
         end
      end
      if (commit_valid_i && commit_kill_i) begin
         foreach (exp_q[i]) if (exp_q[i].id == commit_id_i) exp_q[i].killed = 1;
      end
      if (issue_valid_i && obs_ready && mdl_wb(issue_instr_i)) begin
         exp_q.push_back('{issue_id_i, issue_instr_i[11:7],
                           mdl_result(issue_instr_i, issue_rs1_i, issue_rs2_i), 0});
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      #1;
      checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", issue_ready_o); end
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", result_valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (result_data_o !== '0 || result_id_o !== '0 || result_rd_o !== '0) begin
         errors++; $display("[TB] FAIL reset_result: got data=%h id=%0d rd=%0d want zeros", result_data_o, result_id_o, result_rd_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b want 1", issue_ready_o); end
      @(negedge clk_i);
   endtask

   task automatic test_single_add();
      result_ready_i = 1'b0;
      set_issue(3'd0, 5'd9, 3'd3, 64'd5, 64'd7);
      cycle_step();
      checks++; if ({obs_ready, obs_acc, obs_wb} !== 3'b111) begin
         errors++; $display("[TB] FAIL add_handshake: got ready/acc/wb=%b want 111", {obs_ready, obs_acc, obs_wb});
      end
      drive_idle();
      cycle_step();
      checks++; if (obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL add_early: got rvalid=%b at t+1 want 0", obs_rv); end
      cycle_step();
      checks++; if (obs_rv !== 1'b1 || obs_data !== 64'd12 || obs_id !== 3'd3 || obs_rd !== 5'd9) begin
         errors++; $display("[TB] FAIL add_result: got v=%b data=%0d id=%0d rd=%0d want v=1 data=12 id=3 rd=9", obs_rv, obs_data, obs_id, obs_rd);
      end
      result_ready_i = 1'b1;
      cycle_step();
      checks++; if (!popped || !pop_has_exp || obs_data !== pop_exp.data || obs_id !== pop_exp.id) begin
         errors++; $display("[TB] FAIL add_pop: got popped=%0d data=%h id=%0d want data=%h id=%0d", popped, obs_data, obs_id, pop_exp.data, pop_exp.id);
      end
      cycle_step();
      checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_after: got %b want 0", obs_busy); end
   endtask

   task automatic test_reject();
      bit seen;
      result_ready_i = 1'b1;
      set_issue(3'd5, 5'd4, 3'd1, 64'd1, 64'd2);
      cycle_step();
      checks++; if ({obs_ready, obs_acc, obs_wb} !== 3'b100) begin
         errors++; $display("[TB] FAIL reject_handshake: got ready/acc/wb=%b want 100", {obs_ready, obs_acc, obs_wb});
      end
      drive_idle();
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         cycle_step();
         if (obs_rv || obs_busy) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("[TB] FAIL reject_activity: got result/busy activity=1 want 0"); end
   endtask

   task automatic test_back_pressure();
      int  n;
      bit  done;
      logic [2:0] ready_seen;
      result_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_issue(3'd1, 5'(k + 1), 3'(k), {$urandom, $urandom}, {$urandom, $urandom});
         cycle_step();
         checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_%0d: got %b want 1", k, obs_ready); end
      end
      set_issue(3'd1, 5'd5, 3'd4, {$urandom, $urandom}, {$urandom, $urandom});
      for (int k = 0; k < 3; k++) begin
         cycle_step();
         ready_seen[k] = obs_ready;
      end
      checks++; if (ready_seen !== 3'b000) begin errors++; $display("[TB] FAIL bp_full_stall: got ready=%b want 000", ready_seen); end
      result_ready_i = 1'b1;
      cycle_step();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_full_pop_accept: got ready=%b want 1", obs_ready); end
      n = 0;
      if (popped) begin
         n++;
         checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_data !== pop_exp.data) begin
            errors++; $display("[TB] FAIL bp_result: got id=%0d data=%h want id=%0d data=%h", obs_id, obs_data, pop_exp.id, pop_exp.data);
         end
      end
      drive_idle();
      done = 0;
      for (int c = 0; c < 40; c++) begin
         cycle_step();
         if (popped) begin
            n++;
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL bp_result: got id=%0d data=%h want id=%0d data=%h", obs_id, obs_data, pop_exp.id, pop_exp.data);
            end
         end
         if (!obs_busy) begin done = 1; break; end
      end
      checks++; if (!done || n != 5) begin errors++; $display("[TB] FAIL bp_drain: got drained=%0d results=%0d want drained=1 results=5", done, n); end
   endtask

   task automatic test_kill();
      int n;
      bit done;
      logic [IdWidth-1:0] last_id;
      result_ready_i = 1'b0;
      set_issue(3'd0, 5'd1, 3'd1, 64'd10, 64'd1);
      cycle_step();
      set_issue(3'd0, 5'd2, 3'd2, 64'd20, 64'd2);
      cycle_step();
      set_issue(3'd1, 5'd3, 3'd1, 64'd30, 64'd3);
      cycle_step();
      drive_idle();
      commit_valid_i = 1'b1;
      commit_kill_i  = 1'b1;
      commit_id_i    = 3'd1;
      cycle_step();
      drive_idle();
      result_ready_i = 1'b1;
      n = 0; done = 0; last_id = '0;
      for (int c = 0; c < 40; c++) begin
         cycle_step();
         if (popped) begin
            n++;
            last_id = obs_id;
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL kill_result: got id=%0d data=%h want id=%0d data=%h", obs_id, obs_data, pop_exp.id, pop_exp.data);
            end
         end
         if (!obs_busy) begin done = 1; break; end
      end
      checks++; if (!done || n != 1 || last_id !== 3'd2) begin
         errors++; $display("[TB] FAIL kill_outcome: got drained=%0d results=%0d id=%0d want drained=1 results=1 id=2", done, n, last_id);
      end
   endtask

   task automatic test_wrap_back_to_back();
      int n;
      bit done;
      result_ready_i = 1'b1;
      set_issue(3'd0, 5'd7, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      cycle_step();
      drive_idle();
      cycle_step();
      cycle_step();
      checks++; if (!popped || obs_data !== 64'd0 || obs_id !== 3'd5) begin
         errors++; $display("[TB] FAIL wrap_add: got popped=%0d data=%h id=%0d want data=0 id=5", popped, obs_data, obs_id);
      end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         set_issue(3'($urandom_range(0, 1)), 5'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         cycle_step();
         checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %b want 1", k, obs_ready); end
         if (popped) begin
            n++;
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_rd !== pop_exp.rd || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL b2b_result: got id=%0d rd=%0d data=%h want id=%0d rd=%0d data=%h", obs_id, obs_rd, obs_data, pop_exp.id, pop_exp.rd, pop_exp.data);
            end
         end
      end
      drive_idle();
      done = 0;
      for (int c = 0; c < 40; c++) begin
         cycle_step();
         if (popped) begin
            n++;
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_rd !== pop_exp.rd || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL b2b_result: got id=%0d rd=%0d data=%h want id=%0d rd=%0d data=%h", obs_id, obs_rd, obs_data, pop_exp.id, pop_exp.rd, pop_exp.data);
            end
         end
         if (!obs_busy) begin done = 1; break; end
      end
      checks++; if (!done || n != 20) begin errors++; $display("[TB] FAIL b2b_count: got drained=%0d results=%0d want drained=1 results=20", done, n); end
   endtask

   task automatic test_reset_midop();
      bit stale;
      result_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_issue(3'd0, 5'(k), 3'(k), 64'(k), 64'd100);
         cycle_step();
      end
      drive_idle();
      cycle_step();
      checks++; if (obs_rv !== 1'b1 || obs_busy !== 1'b1) begin
         errors++; $display("[TB] FAIL midop_before: got rvalid=%b busy=%b want 1 1", obs_rv, obs_busy);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (result_valid_o !== 1'b0 || busy_o !== 1'b0 || issue_ready_o !== 1'b0) begin
         errors++; $display("[TB] FAIL midop_reset: got rvalid=%b busy=%b ready=%b want 0 0 0", result_valid_o, busy_o, issue_ready_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      @(posedge clk_i);
      #1;
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL midop_release_ready: got %b want 1", issue_ready_o); end
      @(negedge clk_i);
      result_ready_i = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         cycle_step();
         if (obs_rv || obs_busy) stale = 1;
      end
      checks++; if (stale) begin errors++; $display("[TB] FAIL midop_stale: got stale result/busy=1 want 0"); end
   endtask

   task automatic test_random();
      int         kind;
      logic [2:0] f3;
      logic [6:0] opc;
      bit         partial;
      bit         done;
      for (int c = 0; c < 300; c++) begin
         drive_idle();
         kind    = $urandom_range(0, 4);
         f3      = (kind <= 2) ? 3'(kind) : (kind == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         opc     = (kind == 4) ? 7'h33 : 7'h0B;
         partial = ($urandom_range(0, 9) == 0);
         issue_rs_valid_i = partial ? 2'($urandom_range(0, 2)) : 2'b11;
         issue_valid_i    = ($urandom_range(0, 9) < 7);
         issue_instr_i    = {17'($urandom), f3, 5'($urandom), opc};
         issue_id_i       = 3'($urandom);
         issue_rs1_i      = {$urandom, $urandom};
         issue_rs2_i      = {$urandom, $urandom};
         result_ready_i   = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) == 0) begin
            commit_valid_i = 1'b1;
            commit_kill_i  = 1'b1;
            commit_id_i    = 3'($urandom);
         end
         cycle_step();
         if (partial) begin
            checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL rnd_rs_valid_ready: got %b want 0", obs_ready); end
         end
         if (issue_valid_i) begin
            checks++; if (obs_acc !== mdl_accept(issue_instr_i) || obs_wb !== mdl_wb(issue_instr_i)) begin
               errors++; $display("[TB] FAIL rnd_decode: instr=%h got acc=%b wb=%b want acc=%b wb=%b", issue_instr_i, obs_acc, obs_wb, mdl_accept(issue_instr_i), mdl_wb(issue_instr_i));
            end
         end
         if (popped) begin
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_rd !== pop_exp.rd || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL rnd_result: got id=%0d rd=%0d data=%h want id=%0d rd=%0d data=%h (entry=%0d)", obs_id, obs_rd, obs_data, pop_exp.id, pop_exp.rd, pop_exp.data, pop_has_exp);
            end
         end
      end
      drive_idle();
      issue_rs_valid_i = 2'b11;
      result_ready_i   = 1'b1;
      done = 0;
      for (int c = 0; c < 40; c++) begin
         cycle_step();
         if (popped) begin
            checks++; if (!pop_has_exp || obs_id !== pop_exp.id || obs_rd !== pop_exp.rd || obs_data !== pop_exp.data) begin
               errors++; $display("[TB] FAIL rnd_result: got id=%0d rd=%0d data=%h want id=%0d rd=%0d data=%h (entry=%0d)", obs_id, obs_rd, obs_data, pop_exp.id, pop_exp.rd, pop_exp.data, pop_has_exp);
            end
         end
         if (!obs_busy) begin done = 1; break; end
      end
      while (exp_q.size() > 0 && exp_q[0].killed) void'(exp_q.pop_front());
      checks++; if (!done || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL rnd_drain: got drained=%0d leftover=%0d want drained=1 leftover=0", done, exp_q.size());
      end
   endtask

   initial begin
      rst_i            = 1'b1;
      issue_rs_valid_i = 2'b11;
      result_ready_i   = 1'b0;
      drive_idle();
      test_reset();
      test_single_add();
      test_reject();
      test_back_pressure();
      test_kill();
      test_wrap_back_to_back();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
